// File: rtl/contadores_param_if.sv
// Bus bundle for the pop-counter bank: pop strobes, read request/index in, read result and flags out.
interface contadores_param_if #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 5,
  parameter int IDX_W  = 3
) ();
  logic [NUM_CH-1:0] pop;
  logic              req;
  logic              clr_rd;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic [CNT_W-1:0]  data_out;
  logic              idx_err;
  logic [NUM_CH-1:0] ovf;

  modport master (output pop, req, clr_rd, idx, input valid, data_out, idx_err, ovf);
  modport slave  (input pop, req, clr_rd, idx, output valid, data_out, idx_err, ovf);
endinterface

// File: rtl/contadores_param.sv
// Parametrised pop-counter bank with indexed read and read-with-clear.
// Optional macro CNT_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module contadores_param_lane #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             pop_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (run_i) begin
      if (clr_i) begin
        // A pop landing on the clearing edge still counts
        cnt_d = pop_i ? CNT_W'(1) : '0;
        ovf_d = 1'b0;
      end else if (pop_i) begin
`ifdef CNT_SATURATE_EN
        cnt_d = at_max ? cnt_q : cnt_q + CNT_W'(1);
`else
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      if (pop_i && at_max) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module contadores_param #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 5,
  parameter int IDX_W  = 3
) (
  input logic               clk,
  input logic               reset,
  contadores_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;

  state_t                        state_q, state_d;
  logic                          run;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0]             ovf;
  logic [NUM_CH-1:0]             clr_sel;
  logic                          idx_ok;
  logic [CNT_W-1:0]              rd_val;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic [CNT_W-1:0]              data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run = (state_q == RUN);
  end

  assign idx_ok = ({1'b0, bus.idx} < (IDX_W+1)'(NUM_CH));

  always_comb begin
    rd_val  = '0;
    clr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.idx == IDX_W'(i)) begin
        rd_val     = cnt[i];
        clr_sel[i] = run && bus.req && bus.clr_rd;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    contadores_param_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .run_i (run),
      .pop_i (bus.pop[g]),
      .clr_i (clr_sel[g]),
      .cnt_o (cnt[g]),
      .ovf_o (ovf[g])
    );
  end

  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    if (run && bus.req) begin
      if (idx_ok) begin
        valid_d = 1'b1;
        data_d  = rd_val;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.idx_err  = err_q;
  assign bus.data_out = data_q;
  assign bus.ovf      = ovf;
endmodule

// File: tb/tb_contadores_param.sv
// Directed bench for contadores_param at default parameters; expectations are hand-computed.
module tb_contadores_param;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  contadores_param_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  contadores_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NUM_CH-1:0] p, input logic r, input logic c, input logic [IDX_W-1:0] i);
    bus.pop    = p;
    bus.req    = r;
    bus.clr_rd = c;
    bus.idx    = i;
  endtask

  task automatic rd(input string tag, input logic [IDX_W-1:0] i, input logic [CNT_W-1:0] exp);
    drive('0, 1'b1, 1'b0, i);
    tick();
    chk({tag, "_valid"}, bus.valid, 1);
    chk({tag, "_data"}, bus.data_out, exp);
  endtask

  initial begin
    // Reset held two cycles under full activity
    reset = 1'b1;
    drive(5'h1F, 1'b1, 1'b0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_valid", bus.valid, 0);
      chk("rst_data", bus.data_out, 0);
      chk("rst_err", bus.idx_err, 0);
      chk("rst_ovf", bus.ovf, 0);
    end

    // First edge after release is IDLE: pops and reqs ignored
    reset = 1'b0;
    tick();
    chk("idle_valid", bus.valid, 0);

    // Three pops on ch2, one on ch4
    drive(5'b10100, 1'b0, 1'b0, 3'd0); tick();
    drive(5'b00100, 1'b0, 1'b0, 3'd0); tick();
    tick();
    rd("ch2", 3'd2, 5'd3);
    rd("ch4", 3'd4, 5'd1);
    rd("ch0_idle", 3'd0, 5'd0);

    drive('0, 1'b0, 1'b0, 3'd0);
    tick();
    chk("noreq_valid", bus.valid, 0);
    chk("noreq_hold", bus.data_out, 0);

    // 33 pops on ch0 -> wrap (or saturate)
    drive(5'b00001, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 33; k++) tick();
`ifdef CNT_SATURATE_EN
    rd("wrap0", 3'd0, 5'd31);
`else
    rd("wrap0", 3'd0, 5'd1);
`endif
    chk("wrap_ovf", bus.ovf, 5'b00001);

    // Read-with-clear of ch0 also drops its overflow flag
    drive('0, 1'b1, 1'b1, 3'd0);
    tick();
`ifdef CNT_SATURATE_EN
    chk("clr0_data", bus.data_out, 5'd31);
`else
    chk("clr0_data", bus.data_out, 5'd1);
`endif
    chk("clr0_ovf", bus.ovf, 0);
    rd("clr0_after", 3'd0, 5'd0);

    // ch1 to 7, then read-with-clear with a concurrent pop
    drive(5'b00010, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 7; k++) tick();
    drive(5'b00010, 1'b1, 1'b1, 3'd1);
    tick();
    chk("rwc_valid", bus.valid, 1);
    chk("rwc_data", bus.data_out, 5'd7);
    // Pop plus plain read: old value returned, count still advances
    drive(5'b00010, 1'b1, 1'b0, 3'd1);
    tick();
    chk("popread_data", bus.data_out, 5'd1);
    rd("popread_after", 3'd1, 5'd2);

    // clr_rd without req changes nothing
    drive('0, 1'b0, 1'b1, 3'd1);
    tick();
    rd("clr_noreq", 3'd1, 5'd2);

    // Out-of-range indices
    drive('0, 1'b1, 1'b0, 3'd5);
    tick();
    chk("idx5_err", bus.idx_err, 1);
    chk("idx5_valid", bus.valid, 0);
    chk("idx5_data", bus.data_out, 5'd2);
    drive('0, 1'b1, 1'b0, 3'd7);
    tick();
    chk("idx7_err", bus.idx_err, 1);
    chk("idx7_valid", bus.valid, 0);
    chk("idx7_data", bus.data_out, 5'd2);
    rd("idx3", 3'd3, 5'd0);
    chk("idx3_err", bus.idx_err, 0);

    // Reset right after a request
    drive('0, 1'b1, 1'b0, 3'd2);
    tick();
    chk("prerst_data", bus.data_out, 5'd3);
    reset = 1'b1;
    drive(5'h1F, 1'b0, 1'b0, 3'd0);
    tick();
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_data", bus.data_out, 0);
    reset = 1'b0;
    drive('0, 1'b0, 1'b0, 3'd0);
    tick();
    for (int i = 0; i < NUM_CH; i++) rd("postrst", IDX_W'(i), 5'd0);
    chk("postrst_ovf", bus.ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
